// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Arbitrates ALU/load results into an in-order FIFO and issues
//            one-cycle register-file writes plus a per-register pending map.
// Revision : 1.0
// ============================================================================
module regfile_writeback #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 1 << ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid_i,
    output logic                          alu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         alu_addr_i,
    input  logic [DATA_WIDTH-1:0]         alu_data_i,
    input  logic                          mem_valid_i,
    output logic                          mem_ready_o,
    input  logic [ADDR_WIDTH-1:0]         mem_addr_i,
    input  logic [DATA_WIDTH-1:0]         mem_data_i,
    input  logic                          wb_stall_i,
    output logic                          write_en_o,
    output logic [ADDR_WIDTH-1:0]         write_addr_o,
    output logic [DATA_WIDTH-1:0]         write_data_o,
    output logic [REG_DEPTH-1:0]          pending_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_DEPTH-1:0] valid_q, valid_d;

    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

    logic                  write_en_q;
    logic [ADDR_WIDTH-1:0] write_addr_q;
    logic [DATA_WIDTH-1:0] write_data_q;

    logic                  not_full;
    logic                  push_mem;
    logic                  push_alu;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0] push_data;

    // Readiness is occupancy-only; mem wins any contention for the single push slot.
    assign not_full    = (count_q != FULL_CNT);
    assign mem_ready_o = not_full;
    assign alu_ready_o = not_full & ~mem_valid_i;

    assign push_mem  = mem_valid_i & not_full;
    assign push_alu  = alu_valid_i & alu_ready_o;
    assign push      = push_mem | push_alu;
    assign push_addr = push_mem ? mem_addr_i : alu_addr_i;
    assign push_data = push_mem ? mem_data_i : alu_data_i;
    assign pop       = (count_q != '0) & ~wb_stall_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by valid_q/count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else if (pop) begin
            write_en_q   <= 1'b1;
            write_addr_q <= addr_mem[rd_ptr_q];
            write_data_q <= data_mem[rd_ptr_q];
        end else begin
            write_en_q   <= 1'b0;
        end
    end

    // A register stays pending until its write has left the output stage.
    always_comb begin
        pending_o = '0;
        for (int r = 0; r < REG_DEPTH; r++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (valid_q[e] && (addr_mem[e] == ADDR_WIDTH'(r))) begin
                    pending_o[r] = 1'b1;
                end
            end
            if (write_en_q && (write_addr_q == ADDR_WIDTH'(r))) begin
                pending_o[r] = 1'b1;
            end
        end
    end

    assign write_en_o   = write_en_q;
    assign write_addr_o = write_addr_q;
    assign write_data_o = write_data_q;
    assign fifo_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Randomized and directed scoreboard bench for regfile_writeback.
// Revision : 1.0
// ============================================================================
module tb_regfile_writeback;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int RD = 1 << AW;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid_i = 1'b0;
    logic          alu_ready_o;
    logic [AW-1:0] alu_addr_i = '0;
    logic [DW-1:0] alu_data_i = '0;
    logic          mem_valid_i = 1'b0;
    logic          mem_ready_o;
    logic [AW-1:0] mem_addr_i = '0;
    logic [DW-1:0] mem_data_i = '0;
    logic          wb_stall_i = 1'b0;
    logic          write_en_o;
    logic [AW-1:0] write_addr_o;
    logic [DW-1:0] write_data_o;
    logic [RD-1:0] pending_o;
    logic [$clog2(FD):0] fifo_count_o;

    regfile_writeback #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_DEPTH(RD), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .wb_stall_i(wb_stall_i),
        .write_en_o(write_en_o), .write_addr_o(write_addr_o),
        .write_data_o(write_data_o), .pending_o(pending_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    req_t          alu_q[$];
    req_t          mem_q[$];
    req_t          sb[$];
    logic [AW-1:0] mfifo[$];
    int            outstanding[RD];
    bit            m_wen = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    bit            acc_alu_last = 1'b0;
    bit            acc_mem_last = 1'b0;
    bit            rand_mode = 1'b0;
    int            max_cnt = 0;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: buffer occupancy as a queue, pending as per-register outstanding counts.
    always @(posedge clk) begin
        bit a_mem, a_alu, p;
        if (rst_n) begin
            a_mem = mem_valid_i && (mfifo.size() != FD);
            a_alu = alu_valid_i && (mfifo.size() != FD) && !mem_valid_i;
            p     = (mfifo.size() != 0) && !wb_stall_i;
            if (m_wen) outstanding[m_waddr]--;
            if (p) begin
                m_waddr = mfifo.pop_front();
                m_wen   = 1'b1;
            end else begin
                m_wen   = 1'b0;
            end
            if (a_mem) begin
                mfifo.push_back(mem_addr_i);
                sb.push_back('{a: mem_addr_i, d: mem_data_i});
                outstanding[mem_addr_i]++;
            end else if (a_alu) begin
                mfifo.push_back(alu_addr_i);
                sb.push_back('{a: alu_addr_i, d: alu_data_i});
                outstanding[alu_addr_i]++;
            end
            acc_mem_last = a_mem;
            acc_alu_last = a_alu;
        end
    end

    always @(negedge rst_n) begin
        mfifo.delete();
        sb.delete();
        m_wen        = 1'b0;
        acc_alu_last = 1'b0;
        acc_mem_last = 1'b0;
        for (int r = 0; r < RD; r++) outstanding[r] = 0;
    end

    // Cycle-level checks of timing, occupancy, readiness and pending map.
    always @(negedge clk) begin
        logic [RD-1:0] exp_pend;
        if (rst_n) begin
            for (int r = 0; r < RD; r++) exp_pend[r] = (outstanding[r] != 0);
            chk("write_en", 64'(write_en_o), 64'(m_wen));
            chk("fifo_count", 64'(fifo_count_o), 64'(mfifo.size()));
            chk("mem_ready", 64'(mem_ready_o), 64'(mfifo.size() != FD));
            chk("alu_ready", 64'(alu_ready_o), 64'((mfifo.size() != FD) && !mem_valid_i));
            chk("pending", 64'(pending_o), 64'(exp_pend));
            if (int'(fifo_count_o) > max_cnt) max_cnt = int'(fifo_count_o);
        end
    end

    // Scoreboard monitor: every write strobe retires the oldest accepted result.
    always @(negedge clk) begin
        req_t e;
        if (rst_n && write_en_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write at %0t: actual addr=%0h required none", $time, write_addr_o);
            end else begin
                e = sb.pop_front();
                chk("write_addr", 64'(write_addr_o), 64'(e.a));
                chk("write_data", 64'(write_data_o), 64'(e.d));
            end
        end
    end

    // Producer driver: holds each request until the model sees it accepted.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                alu_valid_i = 1'b0;
                mem_valid_i = 1'b0;
                alu_q.delete();
                mem_q.delete();
            end else begin
                if (acc_alu_last) alu_valid_i = 1'b0;
                if (acc_mem_last) mem_valid_i = 1'b0;
                if (!alu_valid_i && alu_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                    r = alu_q.pop_front();
                    alu_addr_i  = r.a;
                    alu_data_i  = r.d;
                    alu_valid_i = 1'b1;
                end
                if (!mem_valid_i && mem_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                    r = mem_q.pop_front();
                    mem_addr_i  = r.a;
                    mem_data_i  = r.d;
                    mem_valid_i = 1'b1;
                end
                if (rand_mode) wb_stall_i = ($urandom_range(0, 3) == 0);
            end
        end
    end

    function automatic bit idle();
        return (alu_q.size() == 0) && (mem_q.size() == 0) && !alu_valid_i && !mem_valid_i &&
               (mfifo.size() == 0) && !m_wen;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle() && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("idle_reached", 64'(idle()), 64'd1);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_model_cnt(input int want, input int budget);
        int n = 0;
        while (mfifo.size() != want && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("model_fill", 64'(mfifo.size()), 64'(want));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_write_en", 64'(write_en_o), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count_o), 64'd0);
        chk("rst_pending", 64'(pending_o), 64'd0);
        chk("rst_write_addr", 64'(write_addr_o), 64'd0);
        chk("rst_write_data", 64'(write_data_o), 64'd0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("rel_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("rel_mem_ready", 64'(mem_ready_o), 64'd1);

        // Single write
        alu_q.push_back('{a: 5'd5, d: 16'h1234});
        wait_idle(20);

        // Contention: mem and alu offered together
        mem_q.push_back('{a: 5'd3, d: 16'hAAAA});
        alu_q.push_back('{a: 5'd4, d: 16'hBBBB});
        wait_idle(20);

        // Full with backpressure, fifth request held
        wb_stall_i = 1'b1;
        alu_q.push_back('{a: 5'd1, d: 16'h0011});
        alu_q.push_back('{a: 5'd2, d: 16'h0022});
        alu_q.push_back('{a: 5'd3, d: 16'h0033});
        alu_q.push_back('{a: 5'd4, d: 16'h0044});
        alu_q.push_back('{a: 5'd6, d: 16'h0066});
        wait_model_cnt(4, 20);
        repeat (3) @(negedge clk);
        #2;
        chk("full_count", 64'(fifo_count_o), 64'd4);
        chk("full_alu_ready", 64'(alu_ready_o), 64'd0);
        chk("full_mem_ready", 64'(mem_ready_o), 64'd0);
        chk("full_held_valid", 64'(alu_valid_i), 64'd1);
        wb_stall_i = 1'b0;
        wait_idle(30);

        // Same-register hazard
        alu_q.push_back('{a: 5'd7, d: 16'h0001});
        alu_q.push_back('{a: 5'd7, d: 16'h0002});
        wait_idle(20);

        // Wrap-around streaming
        max_cnt = 0;
        for (int i = 0; i < 10; i++) alu_q.push_back('{a: AW'(i + 10), d: DW'(16'h0100 + i)});
        wait_idle(40);
        chk("stream_max_count_le2", 64'(max_cnt <= 2), 64'd1);

        // Randomized mixed traffic with random stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            req_t r;
            r.a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, RD - 1));
            r.d = DW'($urandom);
            if ($urandom_range(0, 1) == 0) alu_q.push_back(r);
            else                           mem_q.push_back(r);
        end
        wait_idle(3000);
        rand_mode = 1'b0;
        @(negedge clk);
        #2 wb_stall_i = 1'b0;

        // Reset mid-operation: three buffered, one in the output stage
        wb_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) alu_q.push_back('{a: AW'(20 + i), d: DW'(16'hC000 + i)});
        wait_model_cnt(4, 20);
        @(negedge clk);
        #2 wb_stall_i = 1'b0;
        @(negedge clk);
        #2 wb_stall_i = 1'b1;
        chk("pre_rst_write_en", 64'(write_en_o), 64'd1);
        chk("pre_rst_count", 64'(fifo_count_o), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_write_en", 64'(write_en_o), 64'd0);
        chk("mid_rst_count", 64'(fifo_count_o), 64'd0);
        chk("mid_rst_pending", 64'(pending_o), 64'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        wb_stall_i = 1'b0;
        @(negedge clk);
        #2;
        chk("post_rst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("post_rst_mem_ready", 64'(mem_ready_o), 64'd1);
        repeat (3) @(negedge clk);
        #2;
        chk("post_rst_no_write", 64'(write_en_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write-side front end for the 3-read/1-write register file. It accepts destination-register results from two producers, the ALU and the memory/load path, over valid/ready handshakes. Results are buffered in a small in-order FIFO and issued as single-cycle write_en/write_addr/write_data pulses to the register file. It also publishes a per-register pending bitmap that operand-read logic uses to stall on outstanding writes.

Parameters:
DATA_WIDTH, 16, register data width
ADDR_WIDTH, 5, register address width
REG_DEPTH, 1 << ADDR_WIDTH, number of registers (pending bitmap width)
FIFO_DEPTH, 4, writeback buffer entries; power of 2, at least 2

Ports:
clk  in  1  single clock, rising-edge
rst_n  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted when valid & ready at clk edge
alu_addr  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted when valid & ready at clk edge
mem_addr  in  ADDR_WIDTH  load destination register
mem_data  in  DATA_WIDTH  load result
wb_stall  in  1  inhibits FIFO pop (register file busy or test)
write_en  out  1  register-file write strobe, active high
write_addr  out  ADDR_WIDTH  register-file write address
write_data  out  DATA_WIDTH  register-file write data
pending  out  REG_DEPTH  bit r high while a write to register r is outstanding
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n is low: FIFO empty, fifo_count=0, write_en=0, write_addr=0, write_data=0, pending=0. alu_ready and mem_ready follow the combinational rules below, so both are 1 after reset.
- Arbitration: at most one push per cycle, fixed priority to mem.
  - mem_ready = (fifo_count != FIFO_DEPTH).
  - alu_ready = (fifo_count != FIFO_DEPTH) & !mem_valid.
  - Readiness depends on occupancy only. There is no push-through-pop bypass when full.
- Handshake: producers hold valid/addr/data stable until accepted. An accepted entry {addr,data} is written at FIFO tail on that edge.
- Output stage: registered write_en/write_addr/write_data. On each edge:
  - If the FIFO is non-empty and wb_stall=0, pop the head into the output stage and set write_en=1.
  - Otherwise write_en=0; write_addr and write_data hold their last values.
  - write_en is high for exactly one cycle per entry.
  - Throughput is 1 write per cycle.
- Latency: push at edge k gives write_en=1 in the cycle after edge k+1, provided the FIFO is empty before the push and wb_stall=0.
- Ordering: strict acceptance order. Two writes to the same register retire in acceptance order.
- Simultaneous push and pop: both occur on the same edge and fifo_count is unchanged.
- Pointer wrap: read/write pointers are modulo FIFO_DEPTH. Full versus empty is distinguished via fifo_count.
- Pending bitmap: combinational from registered state.
  - pending[r] = OR over valid FIFO entries with addr==r, OR (write_en & write_addr==r).
  - It rises in the cycle after the accepting edge.
  - It falls in the cycle after the last matching write_en cycle, so it stays high across multiple outstanding writes to r.
- wb_stall asserted: no pop. Any write already in the output stage still completes its single write_en cycle.
- Reset mid-operation: buffered entries are discarded and write_en drops immediately (asynchronous). There is no partial write afterwards.
- Register 0 receives no special handling.

Test Plan:
- Reset: assert rst_n=0 while 3 entries are queued and write_en=1 -> write_en=0, fifo_count=0, pending=0 immediately; after release alu_ready=mem_ready=1.
- Single write: alu addr=5 data=0x1234 accepted at edge k -> write_en=1, write_addr=5, write_data=0x1234 during the cycle after edge k+1 only; pending[5]=1 from edge k to edge k+2, then 0.
- Contention: mem (3,0xAAAA) and alu (4,0xBBBB) both valid -> mem accepted first with alu_ready=0 that cycle; alu accepted next cycle; writes to reg 3 then reg 4 in consecutive cycles.
- Full/backpressure: wb_stall=1, push (1,0x11),(2,0x22),(3,0x33),(4,0x44) -> fifo_count=4, alu_ready=mem_ready=0, 5th request (6,0x66) held. Drop wb_stall -> writes 1,2,3,4 on 4 consecutive cycles, then 6.
- Same-register hazard: push (7,0x0001) then (7,0x0002) -> two write_en pulses with data 0x0001 then 0x0002; pending[7] stays continuously high until the cycle after the second write.
- Wrap-around: stream 10 back-to-back alu pushes with no stall -> 10 consecutive writes, data in order, fifo_count never exceeds 2.
